spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
//
// PURPOSE
// Byte-level command decoder and register file placed directly downstream of the SPI slave.
// It consumes received bytes (DataReceived_o / Done_o of the slave).
// It supplies the next byte to shift out (DataToSend_i of the slave).
// Frame format: byte 0 is the command: bit7 = 1 write, 0 read; bits[6:0] = start address.
// Following bytes are data, with the address auto-incremented for each byte.
// Fabric logic reads the registers through a separate registered read port.
//
// PARAMETERS
// REG_COUNT    16     number of 8-bit registers, 2..128
// ADDR_WIDTH   4      index width, clog2(REG_COUNT)
// RESET_VALUE  8'h00  value loaded into every register on reset
// STATUS_BYTE  8'hA5  byte returned to the master during the command byte
//
// PORTS
// Clock        in   1           system clock
// Reset        in   1           synchronous, active-high
// CS_i         in   1           SPI chip select, active low, raw pin; synchronized internally with 2 FFs
// RxData_i     in   8           byte received from MOSI, valid while RxDone_i = 1
// RxDone_i     in   1           one-cycle pulse, one received byte
// TxData_o     out  8           next byte for MISO, goes to the slave's DataToSend_i
// WrStrobe_o   out  1           one-cycle pulse per committed SPI write
// WrAddr_o     out  ADDR_WIDTH  address of the write, valid with WrStrobe_o
// WrData_o     out  8           data of the write, valid with WrStrobe_o
// CmdError_o   out  1           frame addressed a register >= REG_COUNT; cleared at next frame start
// UserAddr_i   in   ADDR_WIDTH  fabric read address
// UserData_o   out  8           reg[UserAddr_i], registered; out-of-range address returns 8'h00
//
// BEHAVIOUR
// - Reset values:
//   - all registers = RESET_VALUE; TxData_o = STATUS_BYTE; UserData_o = RESET_VALUE
//   - WrStrobe_o = 0; WrAddr_o = 0; WrData_o = 0; CmdError_o = 0
//   - state = IDLE; CS synchronizer = 2'b11
// - csn = CS_i after the 2-FF synchronizer. All frame logic uses csn.
// - FSM states and transitions:
//   - IDLE:  csn=0 -> CMD; CmdError_o <= 0; TxData_o <= STATUS_BYTE
//   - CMD:   on RxDone_i, capture addr = RxData_i[6:0]
//            - bit7=0 -> READ; TxData_o <= reg[addr] (8'h00 if addr >= REG_COUNT)
//            - bit7=1 -> WRITE
//            - addr >= REG_COUNT -> CmdError_o <= 1 and the invalid flag is set for the whole frame
//   - READ:  on RxDone_i, addr <= addr+1 (wraps REG_COUNT-1 -> 0); TxData_o <= reg[new addr]
//            - the received byte is ignored
//   - WRITE: on RxDone_i with addr valid:
//            - reg[addr] <= RxData_i
//            - WrStrobe_o = 1, WrAddr_o = addr, WrData_o = RxData_i (all in the next cycle)
//            - addr <= addr+1 with wrap
//            - TxData_o <= RxData_i (echo)
//   - WRITE with the invalid flag set: no register change, no strobe, TxData_o <= 8'h00.
//   - Any state, csn=1 -> IDLE; TxData_o <= STATUS_BYTE.
// - Latency:
//   - TxData_o and the write strobe are updated 1 Clock after RxDone_i.
//   - UserData_o is valid 1 Clock after UserAddr_i.
//   - A register written over SPI is visible on UserData_o 2 Clocks after RxDone_i.
// - Invalid addresses: the invalid flag holds for the whole frame, so auto-increment never makes the address valid.
// - Simultaneous events:
//   - RxDone_i in the same cycle csn goes 1: the byte is fully processed (write commits), then next state = IDLE.
//   - RxDone_i while in IDLE: ignored.
// - A frame ended mid-byte produces no RxDone_i, so no partial writes are possible.
// - Reset mid-frame: everything returns to its reset value; the rest of the frame is ignored until csn is seen high and then low again.
// - A fabric read of an address being written in the same cycle returns the old value.
//
// TESTING
// 1. Reset, then read back: UserAddr_i = 0..15 -> UserData_o = 8'h00 for each; TxData_o = 8'hA5.
// 2. CS low, bytes 8'h83,8'h11,8'h22,8'h33, CS high -> regs 3,4,5 = 11,22,33.
//    WrStrobe_o pulses 3 times with WrAddr_o = 3,4,5.
// 3. Read frame 8'h04 then 3 dummy bytes -> TxData_o sequence A5,22,33,00.
// 4. Write 8'h8F,8'hAA,8'hBB -> reg15 = AA, reg0 = BB (wrap).
//    A following read from 0x0F returns AA then BB.
// 5. Write 8'hC0 (addr 64),8'h55 -> CmdError_o = 1, no WrStrobe_o, no register change.
//    CmdError_o clears on the next CS low.
// 6. Frame cut after 4 SCK edges, then a write 8'h82,8'h77 -> only reg2 = 77; no strobe from the cut frame.
//    Also assert Reset mid-frame -> all registers back to 00.

Source files
------------

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: command decoder and byte-wide register file behind an SPI slave.
// Byte 0 of a frame is the command (bit7 = write, bits[6:0] = start address).
// Each following byte is a data byte, and the address auto-increments after every byte.
// Fabric logic reads the registers through a separate registered port.
module spi_reg_bank #(
    parameter int          REG_COUNT   = 16,
    parameter int          ADDR_WIDTH  = 4,
    parameter logic [7:0]  RESET_VALUE = 8'h00,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CS_i,
    input  logic [7:0]            RxData_i,
    input  logic                  RxDone_i,
    output logic [7:0]            TxData_o,
    output logic                  WrStrobe_o,
    output logic [ADDR_WIDTH-1:0] WrAddr_o,
    output logic [7:0]            WrData_o,
    output logic                  CmdError_o,
    input  logic [ADDR_WIDTH-1:0] UserAddr_i,
    output logic [7:0]            UserData_o
);

    typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

    logic [7:0]            regs [REG_COUNT];
    logic [1:0]            cs_sync;
    logic [1:0]            sync_fill;
    logic                  armed;
    logic                  csn;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic                  invalid, invalid_n;
    logic [7:0]            tx_n;
    logic                  err_n;
    logic                  wr_en;
    logic [6:0]            cmd_addr;
    logic                  cmd_ok;

    assign csn      = cs_sync[1];
    assign cmd_addr = RxData_i[6:0];
    assign cmd_ok   = int'(cmd_addr) < REG_COUNT;

    // Two-flop chip-select synchronizer, plus an arm flag that requires a genuine
    // high level on the pin after reset before a new frame may begin.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples
        // pre-edge values regardless of the order the statements are written in.
        if (Reset) begin
            cs_sync   <= 2'b11;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], CS_i};
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & csn);
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic and next values for address, invalid flag, MISO byte and error flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        state_n   = state;
        addr_n    = addr;
        invalid_n = invalid;
        tx_n      = TxData_o;
        err_n     = CmdError_o;
        wr_en     = 1'b0;

        case (state)
            IDLE: begin
                tx_n = STATUS_BYTE;
                if (!csn && armed) begin
                    state_n = CMD;
                    err_n   = 1'b0;
                end
            end
            CMD: begin
                if (RxDone_i) begin
                    addr_n    = cmd_addr[ADDR_WIDTH-1:0];
                    invalid_n = !cmd_ok;
                    if (!cmd_ok) err_n = 1'b1;
                    if (RxData_i[7]) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                        tx_n    = cmd_ok ? regs[cmd_addr[ADDR_WIDTH-1:0]] : 8'h00;
                    end
                end
            end
            READ: begin
                if (RxDone_i) begin
                    addr_n = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                    tx_n   = invalid ? 8'h00 : regs[addr_n];
                end
            end
            WRITE: begin
                if (RxDone_i) begin
                    if (!invalid) begin
                        wr_en  = 1'b1;
                        addr_n = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                        tx_n   = RxData_i;
                    end else begin
                        tx_n   = 8'h00;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Chip select released: the byte above is still committed, then the frame ends.
        if (csn) begin
            state_n = IDLE;
            tx_n    = STATUS_BYTE;
        end
    end

    // Frame registers: address pointer, invalid flag, MISO byte, error flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr       <= '0;
            invalid    <= 1'b0;
            TxData_o   <= STATUS_BYTE;
            CmdError_o <= 1'b0;
        end else begin
            addr       <= addr_n;
            invalid    <= invalid_n;
            TxData_o   <= tx_n;
            CmdError_o <= err_n;
        end
    end

    // Write notification to the fabric, one cycle after the received byte.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            WrStrobe_o <= 1'b0;
            WrAddr_o   <= '0;
            WrData_o   <= 8'h00;
        end else begin
            WrStrobe_o <= wr_en;
            if (wr_en) begin
                WrAddr_o <= addr;
                WrData_o <= RxData_i;
            end
        end
    end

    // Register file update from SPI writes.
    always_ff @(posedge Clock) begin
        // NOTE: the register file is reset explicitly because every register has a
        // defined reset value; this keeps it in flops rather than a RAM macro.
        if (Reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VALUE;
        end else if (wr_en) begin
            regs[addr] <= RxData_i;
        end
    end

    // Registered fabric read port; a same-cycle SPI write yields the old value.
    always_ff @(posedge Clock) begin
        if (Reset)                             UserData_o <= RESET_VALUE;
        else if (int'(UserAddr_i) < REG_COUNT) UserData_o <= regs[UserAddr_i];
        else                                   UserData_o <= 8'h00;
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames followed by random frames,
// checked against a frame-level reference model of the register bank.
module tb_spi_reg_bank;

    localparam int RC = 16;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       CS_i;
    logic [7:0] RxData_i;
    logic       RxDone_i;
    logic [7:0] TxData_o;
    logic       WrStrobe_o;
    logic [3:0] WrAddr_o;
    logic [7:0] WrData_o;
    logic       CmdError_o;
    logic [3:0] UserAddr_i;
    logic [7:0] UserData_o;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mdl [RC];
    logic [7:0] fb [$];
    int         st_addr [$];
    logic [7:0] st_data [$];

    spi_reg_bank dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .CS_i       (CS_i),
        .RxData_i   (RxData_i),
        .RxDone_i   (RxDone_i),
        .TxData_o   (TxData_o),
        .WrStrobe_o (WrStrobe_o),
        .WrAddr_o   (WrAddr_o),
        .WrData_o   (WrData_o),
        .CmdError_o (CmdError_o),
        .UserAddr_i (UserAddr_i),
        .UserData_o (UserData_o)
    );

    always #5 Clock = ~Clock;

    // Record every write strobe seen by the fabric.
    always @(negedge Clock) begin
        if (WrStrobe_o === 1'b1) begin
            st_addr.push_back(int'(WrAddr_o));
            st_data.push_back(WrData_o);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic cs_low();
        CS_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        CS_i = 1'b1;
        repeat (4) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        RxData_i = b;
        RxDone_i = 1'b1;
        tick();
        RxDone_i = 1'b0;
        RxData_i = $urandom_range(0, 255);
        repeat (2) tick();
    endtask

    task automatic check_user(input int a);
        UserAddr_i = a[3:0];
        tick();
        check("user_data", UserData_o, mdl[a]);
    endtask

    task automatic check_all_regs();
        for (int a = 0; a < RC; a++) check_user(a);
    endtask

    // Reference: what the master should receive for each byte of the frame in fb,
    // and which writes the frame commits, derived from the frame rules.
    task automatic run_frame();
        logic [7:0] exp_tx [$];
        int         exp_wa [$];
        logic [7:0] exp_wd [$];
        int         n;
        int         start;
        bit         wr;
        bit         ok;
        n     = fb.size();
        start = int'(fb[0][6:0]);
        wr    = fb[0][7];
        ok    = start < RC;
        exp_tx.push_back(8'hA5);
        for (int i = 1; i < n; i++) begin
            if (wr) exp_tx.push_back(i == 1 ? 8'hA5 : (ok ? fb[i-1] : 8'h00));
            else    exp_tx.push_back(ok ? mdl[(start + i - 1) % RC] : 8'h00);
            if (wr && ok) begin
                exp_wa.push_back((start + i - 1) % RC);
                exp_wd.push_back(fb[i]);
            end
        end

        st_addr.delete();
        st_data.delete();
        cs_low();
        check("err_clear_at_start", CmdError_o, 0);
        for (int i = 0; i < n; i++) begin
            check("tx_byte", TxData_o, exp_tx[i]);
            send_byte(fb[i]);
        end
        cs_high();
        check("tx_idle", TxData_o, 8'hA5);
        check("strobe_count", st_addr.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < st_addr.size(); i++) begin
            check("strobe_addr", st_addr[i], exp_wa[i]);
            check("strobe_data", st_data[i], exp_wd[i]);
        end
        check("cmd_error", CmdError_o, ok ? 0 : 1);
        for (int i = 0; i < exp_wa.size(); i++) mdl[exp_wa[i]] = exp_wd[i];
    endtask

    initial begin
        int n;
        int a;
        Reset      = 1'b1;
        CS_i       = 1'b1;
        RxData_i   = 8'h00;
        RxDone_i   = 1'b0;
        UserAddr_i = 4'd0;
        for (int i = 0; i < RC; i++) mdl[i] = 8'h00;
        repeat (3) tick();

        // Reset state.
        check("rst_tx", TxData_o, 8'hA5);
        check("rst_strobe", WrStrobe_o, 0);
        check("rst_wraddr", WrAddr_o, 0);
        check("rst_wrdata", WrData_o, 0);
        check("rst_err", CmdError_o, 0);
        check("rst_user", UserData_o, 8'h00);
        Reset = 1'b0;
        repeat (4) tick();
        check_all_regs();

        // Write 3 registers with auto-increment.
        fb = '{8'h83, 8'h11, 8'h22, 8'h33};
        run_frame();
        check_all_regs();

        // Write latency: strobe and echo after 1 clock, fabric view after 2.
        cs_low();
        send_byte(8'h83);
        UserAddr_i = 4'd3;
        RxData_i   = 8'h5A;
        RxDone_i   = 1'b1;
        tick();
        RxDone_i   = 1'b0;
        check("lat_strobe", WrStrobe_o, 1);
        check("lat_wraddr", WrAddr_o, 3);
        check("lat_wrdata", WrData_o, 8'h5A);
        check("lat_echo", TxData_o, 8'h5A);
        check("lat_user_old", UserData_o, 8'h11);
        tick();
        check("lat_user_new", UserData_o, 8'h5A);
        check("lat_strobe_off", WrStrobe_o, 0);
        cs_high();
        mdl[3] = 8'h5A;

        // Read frame: A5, 22, 33, 00.
        fb = '{8'h04, 8'h00, 8'hFF, 8'h00};
        run_frame();

        // Write wrap 15 -> 0, then read across the wrap.
        fb = '{8'h8F, 8'hAA, 8'hBB};
        run_frame();
        fb = '{8'h0F, 8'h00, 8'h00};
        run_frame();
        check_user(15);
        check_user(0);

        // Out-of-range command address: error, no writes; cleared by the next frame.
        fb = '{8'hC0, 8'h55};
        run_frame();
        check_all_regs();

        // Frame cut before any full byte, then a normal write.
        st_addr.delete();
        cs_low();
        repeat (4) tick();
        cs_high();
        check("cut_no_strobe", st_addr.size(), 0);
        fb = '{8'h82, 8'h77};
        run_frame();
        check_all_regs();

        // Reset in the middle of a write frame; rest of frame ignored.
        cs_low();
        send_byte(8'h80);
        send_byte(8'h99);
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        st_addr.delete();
        send_byte(8'h81);
        send_byte(8'h44);
        check("rstmid_tx", TxData_o, 8'hA5);
        cs_high();
        check("rstmid_no_strobe", st_addr.size(), 0);
        check("rstmid_err", CmdError_o, 0);
        for (int i = 0; i < RC; i++) mdl[i] = 8'h00;
        check_all_regs();

        // Random frames against the model.
        for (int k = 0; k < 30; k++) begin
            n = $urandom_range(1, 5);
            fb.delete();
            if ($urandom_range(0, 5) == 0) a = $urandom_range(16, 127);
            else                           a = $urandom_range(0, 15);
            fb.push_back({1'($urandom_range(0, 1)), a[6:0]});
            for (int i = 1; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
            run_frame();
            repeat (3) check_user($urandom_range(0, RC - 1));
        end
        check_all_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
